imm_encode: RTL and testbench
=============================

Name: imm_encode

Overview:
Inverse of the immediate extender: merges a 32-bit signed/unsigned immediate into the immediate fields of a base RISC-V instruction word.
- Formats: I, S, B, J, U, using the same 3-bit ImmSrc codes as the datapath decoder.
- Also checks that the immediate is representable in the selected format.
- Used by the instruction-memory loader and the self-test sequencer to build instruction words on the fly.
- Two-stage valid/ready pipeline with a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.
U_LOW_CHECK, 1, when 1 a U-type immediate with nonzero Imm[11:0] is an error; when 0 the low bits are silently dropped.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
ImmSrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101-111 invalid
Imm  input  32  immediate value, two's complement
BaseInstr  input  32  instruction with opcode/rd/rs/funct set; immediate bit positions are don't-care (overwritten)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Instr  output  32  encoded instruction
ImmErr  output  2  00 ok, 01 out of range, 10 misaligned, 11 invalid ImmSrc
ErrCount  output  ERR_CNT_W  number of results delivered with ImmErr != 00, saturating

Behaviour:
- Reset (async assert, sync-release assumption on reset_n deassert): out_valid=0, Instr=0, ImmErr=00, ErrCount=0, both stage valids cleared. in_ready=1 from the first clock after reset.
- Reset mid-operation discards all in-flight requests; nothing is output afterwards for them.
- Stage 1 (S1) registers the inputs on in_valid&&in_ready.
- Stage 2 (S2) registers the packed word and error code when S1 advances.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput: 1 per cycle.
- Ready chain: S2 may load when !s2_valid || out_ready. in_ready = !s1_valid || S2 may load. Combinational path from out_ready to in_ready is permitted.
- out_valid, Instr and ImmErr stay stable while out_valid && !out_ready. Order is strictly preserved; at most 2 requests are in flight.
- Packing: non-immediate bits are passed through from BaseInstr.
  - I: Instr[31:20]=Imm[11:0].
  - S: Instr[31:25]=Imm[11:5], Instr[11:7]=Imm[4:0].
  - B: Instr[31]=Imm[12], Instr[30:25]=Imm[10:5], Instr[11:8]=Imm[4:1], Instr[7]=Imm[11].
  - J: Instr[31]=Imm[20], Instr[30:21]=Imm[10:1], Instr[20]=Imm[11], Instr[19:12]=Imm[19:12].
  - U: Instr[31:12]=Imm[31:12].
- Range rules:
  - I/S: Imm must sign-extend from bit 11.
  - B: must sign-extend from bit 12.
  - J: must sign-extend from bit 20.
  - U: Imm[11:0]==0 when U_LOW_CHECK=1.
- Alignment rule (B/J): Imm[0] must be 0.
- Error priority: invalid ImmSrc > misaligned > out of range.
- On any error the word is still packed from the truncated bits. For invalid ImmSrc, Instr=BaseInstr.
- ErrCount increments on each out handshake (out_valid&&out_ready) with ImmErr!=00. It holds at 2^ERR_CNT_W-1 and is cleared only by reset.

Optional Feature:
IMM_ROUNDTRIP_CHECK_EN.
- Defined: S2 re-decodes its packed Instr per ImmSrc (sign extension from the format's top immediate bit) and compares the result with the stored Imm. A mismatch on an ImmErr==00 result raises a simulation assertion error; the stored Imm adds 32 flops to S2.
- Undefined: no re-decode logic, no extra flops; behaviour is otherwise identical.

Decomposition:
- Package imm_pkg holds:
  - the ImmSrc enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U);
  - the ImmErr enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_SRC);
  - the per-format width constants (12, 12, 13, 21, 32).
- One combinational sub-module, imm_pack, takes BaseInstr, Imm and ImmSrc and returns the packed word and error code. It sits between S1 and S2.
- imm_encode owns the pipeline registers, handshake logic and counter.

Test Plan:
- I, Imm=0xFFFFF800, BaseInstr=0x00000013, out_ready=1 -> 2 cycles later Instr=0x80000013, ImmErr=00, ErrCount=0.
- I, Imm=0x00000800 -> ImmErr=01, Instr[31:20]=0x800, ErrCount=1 after the handshake.
- B, Imm=0xFFFFFFFE, BaseInstr=0x00000063 -> Instr=0xFE000FE3, ImmErr=00. Then Imm=0x00000003 -> ImmErr=10.
- J, Imm=0x00000800, BaseInstr=0x0000006F -> Instr=0x0010006F. U, Imm=0x12345001 -> ImmErr=01, Instr[31:12]=0x12345. ImmSrc=111 -> ImmErr=11, Instr=BaseInstr.
- Backpressure: out_ready=0 for 4 cycles, in_valid held high with 3 distinct requests -> exactly 2 accepted, in_ready=0 after that. Release -> outputs in order at 1/cycle, and Instr is stable while stalled.
- Drive 300 consecutive errored requests -> ErrCount saturates at 255. Assert reset_n=0 with 2 in flight -> out_valid=0 immediately, ErrCount=0, no stale output after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and helpers for the RISC-V immediate encoder: format codes,
// error codes, per-format immediate widths and a signed-fit test.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_SRC   = 2'b11
    } imm_err_e;

    localparam int unsigned IMM_W_I = 12;
    localparam int unsigned IMM_W_S = 12;
    localparam int unsigned IMM_W_B = 13;
    localparam int unsigned IMM_W_J = 21;
    localparam int unsigned IMM_W_U = 32;

    // True when v is the sign extension of its low w bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic [31:0] hi;
        hi = $signed(v) >>> (w - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    // Extracts the immediate back out of an encoded word, sign-extended from
    // the format's top immediate bit.
    function automatic logic [31:0] imm_decode(input logic [31:0] instr, input logic [2:0] src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate into the immediate fields of a
// base instruction and classifies it as ok / out of range / misaligned / bad format.
module imm_pack
    import imm_pkg::*;
#(
    parameter bit U_LOW_CHECK = 1'b1
) (
    input  logic [31:0] base_instr_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  src_i,
    output logic [31:0] instr_o,
    output imm_err_e    err_o
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        instr_o = base_instr_i;
        err_o   = ERR_NONE;
        case (src_i)
            IMM_I: begin
                instr_o[31:20] = imm_i[11:0];
                if (!fits_signed(imm_i, IMM_W_I)) err_o = ERR_RANGE;
            end
            IMM_S: begin
                instr_o[31:25] = imm_i[11:5];
                instr_o[11:7]  = imm_i[4:0];
                if (!fits_signed(imm_i, IMM_W_S)) err_o = ERR_RANGE;
            end
            IMM_B: begin
                instr_o[31]    = imm_i[12];
                instr_o[30:25] = imm_i[10:5];
                instr_o[11:8]  = imm_i[4:1];
                instr_o[7]     = imm_i[11];
                if (imm_i[0])                          err_o = ERR_ALIGN;
                else if (!fits_signed(imm_i, IMM_W_B)) err_o = ERR_RANGE;
            end
            IMM_J: begin
                instr_o[31]    = imm_i[20];
                instr_o[30:21] = imm_i[10:1];
                instr_o[20]    = imm_i[11];
                instr_o[19:12] = imm_i[19:12];
                if (imm_i[0])                          err_o = ERR_ALIGN;
                else if (!fits_signed(imm_i, IMM_W_J)) err_o = ERR_RANGE;
            end
            IMM_U: begin
                instr_o[31:12] = imm_i[31:12];
                if (U_LOW_CHECK && (imm_i[11:0] != 12'h000)) err_o = ERR_RANGE;
            end
            default: err_o = ERR_SRC;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Two-stage valid/ready immediate encoder with a saturating error counter.
// Define IMM_ROUNDTRIP_CHECK_EN to re-decode each result and assert it matches.
module imm_encode
    import imm_pkg::*;
#(
    parameter int unsigned ERR_CNT_W   = 8,
    parameter bit          U_LOW_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           ImmSrc,
    input  logic [31:0]          Imm,
    input  logic [31:0]          BaseInstr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          Instr,
    output logic [1:0]           ImmErr,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_src_q, s1_src_d;
    logic [31:0]          s1_imm_q, s1_imm_d;
    logic [31:0]          s1_base_q, s1_base_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    imm_err_e             s2_err_q, s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        s2_load, s1_accept, s1_advance, out_fire;
    logic [31:0] pack_instr;
    imm_err_e    pack_err;

    assign s2_load    = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load;
    assign s1_accept  = in_valid && in_ready;
    assign s1_advance = s1_valid_q && s2_load;
    assign out_fire   = s2_valid_q && out_ready;

    imm_pack #(.U_LOW_CHECK(U_LOW_CHECK)) u_pack (
        .base_instr_i (s1_base_q),
        .imm_i        (s1_imm_q),
        .src_i        (s1_src_q),
        .instr_o      (pack_instr),
        .err_o        (pack_err)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_accept) begin
            s1_valid_d = 1'b1;
            s1_src_d   = ImmSrc;
            s1_imm_d   = Imm;
            s1_base_d  = BaseInstr;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) s2_valid_d = s1_valid_q;
        if (s1_advance) begin
            s2_instr_d = pack_instr;
            s2_err_d   = pack_err;
        end

        if (out_fire && (s2_err_q != ERR_NONE) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= ERR_NONE;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // NOTE: the S1 payload is deliberately left without reset; it is only
    // ever consumed when s1_valid_q is set, which is reset.
    always_ff @(posedge clk) begin
        s1_src_q  <= s1_src_d;
        s1_imm_q  <= s1_imm_d;
        s1_base_q <= s1_base_d;
    end

    assign out_valid = s2_valid_q;
    assign Instr     = s2_instr_q;
    assign ImmErr    = s2_err_q;
    assign ErrCount  = err_cnt_q;

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic [31:0] s2_imm_q;
    logic [2:0]  s2_src_q;
    logic [31:0] rt_imm, rt_ref;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_imm_q <= '0;
            s2_src_q <= '0;
        end else if (s1_advance) begin
            s2_imm_q <= s1_imm_q;
            s2_src_q <= s1_src_q;
        end
    end

    // U-type only carries Imm[31:12]; low bits may be legally dropped.
    assign rt_imm = imm_decode(s2_instr_q, s2_src_q);
    assign rt_ref = (s2_src_q == IMM_U) ? {s2_imm_q[31:12], 12'h000} : s2_imm_q;

    a_roundtrip : assert property (@(posedge clk) disable iff (!reset_n)
        (s2_valid_q && (s2_err_q == ERR_NONE)) |-> (rt_imm == rt_ref))
        else $error("imm_encode roundtrip: decoded %08h stored %08h", rt_imm, rt_ref);
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Randomized self-checking bench for imm_encode against a table-driven
// reference model and an in-order scoreboard of expected results.
module tb_imm_encode;

    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [2:0]           ImmSrc = '0;
    logic [31:0]          Imm = '0;
    logic [31:0]          BaseInstr = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          Instr;
    logic [1:0]           ImmErr;
    logic [ERR_CNT_W-1:0] ErrCount;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  err;
    } result_t;

    result_t     exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          model_cnt = 0;
    int          delivered_cnt = 0;
    logic [31:0] last_instr;
    logic [1:0]  last_err;
    logic        stall_q = 1'b0;
    logic [31:0] hold_instr;
    logic [1:0]  hold_err;

    imm_encode #(.ERR_CNT_W(ERR_CNT_W), .U_LOW_CHECK(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .Imm       (Imm),
        .BaseInstr (BaseInstr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .ImmErr    (ImmErr),
        .ErrCount  (ErrCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Which immediate bit lands on instruction bit b for each format (-1: none).
    function automatic int imm_index(input logic [2:0] src, input int b);
        case (src)
            3'd0: return (b >= 20) ? b - 20 : -1;
            3'd1: begin
                if (b >= 25) return b - 20;
                if (b >= 7 && b <= 11) return b - 7;
                return -1;
            end
            3'd2: begin
                if (b == 31) return 12;
                if (b >= 25) return b - 20;
                if (b >= 8 && b <= 11) return b - 7;
                if (b == 7) return 11;
                return -1;
            end
            3'd3: begin
                if (b == 31) return 20;
                if (b >= 21) return b - 20;
                if (b == 20) return 11;
                if (b >= 12) return b;
                return -1;
            end
            3'd4: return (b >= 12) ? b : -1;
            default: return -1;
        endcase
    endfunction

    function automatic result_t model(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
        result_t r;
        longint  v;
        longint  lim;
        int      w;
        int      k;
        r.instr = base;
        r.err   = 2'd0;
        if (src > 3'd4) begin
            r.err = 2'd3;
            return r;
        end
        for (int b = 0; b < 32; b++) begin
            k = imm_index(src, b);
            if (k >= 0) r.instr[b] = imm[k];
        end
        w   = (src <= 3'd1) ? 12 : (src == 3'd2) ? 13 : 21;
        v   = longint'($signed(imm));
        lim = longint'(1) << (w - 1);
        if ((src == 3'd2 || src == 3'd3) && imm[0])
            r.err = 2'd2;
        else if (src == 3'd4)
            r.err = ((imm % 32'd4096) != 0) ? 2'd1 : 2'd0;
        else if (v < -lim || v >= lim)
            r.err = 2'd1;
        return r;
    endfunction

    // Scoreboard: observes both handshakes mid-cycle, when inputs and state are settled.
    always @(negedge clk) begin
        result_t e;
        if (!reset_n) begin
            exp_q.delete();
            model_cnt = 0;
            stall_q   = 1'b0;
        end else begin
            check("err_count", ErrCount, model_cnt);
            if (stall_q) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_instr", Instr, hold_instr);
                check("stall_err", ImmErr, hold_err);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", Instr, e.instr);
                    check("imm_err", ImmErr, e.err);
                    if (e.err != 2'd0 && model_cnt < CNT_MAX) model_cnt++;
                end
                last_instr = Instr;
                last_err   = ImmErr;
                delivered_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(ImmSrc, Imm, BaseInstr));
            stall_q    = out_valid && !out_ready;
            hold_instr = Instr;
            hold_err   = ImmErr;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input bit rnd_ready);
        bit acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        ImmSrc    = src;
        Imm       = imm;
        BaseInstr = base;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_out(input string tag);
        int start;
        bit got;
        start = delivered_cnt;
        got   = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1;
            got = (delivered_cnt != start);
        end
        if (!got) check(tag, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [31:0] bounds [12] = '{32'h000007FF, 32'h00000800, 32'hFFFFF800, 32'hFFFFF7FF,
                                 32'h00000FFE, 32'h00001000, 32'hFFFFF000, 32'hFFFFEFFE,
                                 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_base;
        logic [2:0]  r_src;
        int          acc_n;
        int          d0;

        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_instr", Instr, 32'h0);
        check("rst_imm_err", ImmErr, 2'b00);
        check("rst_err_count", ErrCount, 0);
        #21 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Latency with free-flowing output.
        in_valid = 1'b1; ImmSrc = 3'd0; Imm = 32'hFFFFF800; BaseInstr = 32'h00000013;
        out_ready = 1'b1;
        @(negedge clk);
        check("lat_accept", in_ready, 1'b1);
        check("lat_c0", out_valid, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1", out_valid, 1'b0);
        @(negedge clk);
        #1;
        check("lat_c2", out_valid, 1'b1);
        check("i_neg_instr", last_instr, 32'h80000013);
        check("i_neg_err", last_err, 2'b00);
        @(posedge clk);
        #1;
        check("i_neg_cnt", ErrCount, 0);

        send(3'd0, 32'h00000800, 32'h00000013, 1'b0);
        wait_out("to_i_range");
        check("i_range_err", last_err, 2'b01);
        check("i_range_field", last_instr[31:20], 12'h800);
        check("i_range_cnt", ErrCount, 1);

        send(3'd2, 32'hFFFFFFFE, 32'h00000063, 1'b0);
        wait_out("to_b_ok");
        check("b_ok_instr", last_instr, 32'hFE000FE3);
        check("b_ok_err", last_err, 2'b00);
        send(3'd2, 32'h00000003, 32'h00000063, 1'b0);
        wait_out("to_b_align");
        check("b_align_err", last_err, 2'b10);

        send(3'd3, 32'h00000800, 32'h0000006F, 1'b0);
        wait_out("to_j");
        check("j_instr", last_instr, 32'h0010006F);
        check("j_err", last_err, 2'b00);

        send(3'd4, 32'h12345001, 32'h00000037, 1'b0);
        wait_out("to_u");
        check("u_err", last_err, 2'b01);
        check("u_field", last_instr[31:12], 20'h12345);

        send(3'd7, 32'h00000004, 32'h12345677, 1'b0);
        wait_out("to_src");
        check("src_err", last_err, 2'b11);
        check("src_instr", last_instr, 32'h12345677);

        // Backpressure: 4 stalled cycles offering 3 distinct requests.
        out_ready = 1'b0;
        acc_n     = 0;
        in_valid  = 1'b1; ImmSrc = 3'd0; BaseInstr = 32'h00000013; Imm = 32'h00000011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready) acc_n++;
            @(posedge clk);
            #1;
            Imm = 32'h00000011 * (acc_n + 1);
        end
        check("bp_accepted", acc_n, 2);
        check("bp_in_ready", in_ready, 1'b0);
        d0        = delivered_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_rel_c0", delivered_cnt, d0 + 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("bp_rel_c1", delivered_cnt, d0 + 2);
        drain();
        check("bp_total", delivered_cnt, d0 + 3);

        // Randomized traffic with random output stalls.
        for (int i = 0; i < 400; i++) begin
            r_src  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            r_base = $urandom;
            case ($urandom_range(0, 3))
                0: r_imm = $urandom;
                1: r_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: r_imm = bounds[$urandom_range(0, 11)];
                default: begin
                    r_imm = $urandom;
                    r_imm = r_imm & 32'hFFFFF000;
                end
            endcase
            if ($urandom_range(0, 1) == 0) r_imm[0] = 1'b0;
            send(r_src, r_imm, r_base, 1'b1);
        end
        drain();

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            r_imm  = $urandom;
            r_base = $urandom;
            send(3'($urandom_range(5, 7)), r_imm, r_base, 1'b0);
        end
        drain();
        @(posedge clk);
        #1;
        check("sat_count", ErrCount, CNT_MAX);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        send(3'd0, 32'h00000001, 32'h00000013, 1'b0);
        send(3'd0, 32'h00000002, 32'h00000013, 1'b0);
        check("rst2_prefill", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst2_out_valid", out_valid, 1'b0);
        check("rst2_err_count", ErrCount, 0);
        check("rst2_instr", Instr, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        d0        = delivered_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst2_no_stale", out_valid, 1'b0);
        end
        check("rst2_delivered", delivered_cnt, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
